// File: rtl/sha3_squeeze_serializer.sv
// sha3_squeeze_serializer: streams a SHA3/SHAKE rate block as OUT_W-bit words.
// Fixed modes are trimmed to the digest length. SHAKE modes span several
// squeeze blocks and request each further block from the permutation core.
// Optional build macro: SHA3_SER_DROP_FLAG_EN adds the sticky drop_o flag.
module sha3_squeeze_serializer #(
    parameter int OUT_W  = 64,
    parameter int RATE_W = 1344,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                md_valid_i,
    input  logic [0:RATE_W-1]   din_i,
    input  logic [2:0]          mode_sel_i,
    input  logic [LEN_W-1:0]    len_words_i,
    output logic                in_ready_o,
    output logic                squeeze_req_o,
    output logic [OUT_W-1:0]    dout_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                blk_last_o,
    output logic                last_o,
    output logic                done_o
`ifdef SHA3_SER_DROP_FLAG_EN
    ,
    output logic                drop_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT_BLK
    } state_t;

    typedef enum logic [2:0] {
        M_SHAKE128 = 3'd0,
        M_SHAKE256 = 3'd1,
        M_SHA3_512 = 3'd2,
        M_SHA3_384 = 3'd3,
        M_SHA3_256 = 3'd4,
        M_SHA3_224 = 3'd5
    } mode_t;

    // Words per block for each mode (fixed modes rounded up to whole words)
    localparam int WPB_128 = RATE_W / OUT_W;
    localparam int WPB_256 = 1088 / OUT_W;
    localparam int WPB_512 = (512 + OUT_W - 1) / OUT_W;
    localparam int WPB_384 = (384 + OUT_W - 1) / OUT_W;
    localparam int WPB_S256 = (256 + OUT_W - 1) / OUT_W;
    localparam int WPB_224 = (224 + OUT_W - 1) / OUT_W;

    state_t             state_q, state_d;
    mode_t              mode_in, mode_q;
    logic [0:RATE_W-1]  sreg_q;
    logic [LEN_W-1:0]   idx_q, wpb_q, rem_q;
    logic [LEN_W-1:0]   wpb_in, tot_in;
    logic               done_q, sq_q;
    logic               accept, hs;
    logic [OUT_W-1:0]   word;

    assign accept = md_valid_i & in_ready_o;
    assign hs     = out_valid_o & out_ready_i;

    // Decode the incoming mode (reserved codes behave as SHA3-256) and its sizes
    always_comb begin
        mode_in = M_SHA3_256;
        wpb_in  = LEN_W'(WPB_S256);
        case (mode_sel_i)
            3'd0: begin mode_in = M_SHAKE128; wpb_in = LEN_W'(WPB_128);  end
            3'd1: begin mode_in = M_SHAKE256; wpb_in = LEN_W'(WPB_256);  end
            3'd2: begin mode_in = M_SHA3_512; wpb_in = LEN_W'(WPB_512);  end
            3'd3: begin mode_in = M_SHA3_384; wpb_in = LEN_W'(WPB_384);  end
            3'd5: begin mode_in = M_SHA3_224; wpb_in = LEN_W'(WPB_224);  end
            default: begin mode_in = M_SHA3_256; wpb_in = LEN_W'(WPB_S256); end
        endcase
        tot_in = wpb_in;
        if (mode_in == M_SHAKE128 || mode_in == M_SHAKE256)
            tot_in = (len_words_i == '0) ? LEN_W'(1) : len_words_i;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (md_valid_i) state_d = ST_STREAM;
            ST_STREAM: begin
                if (hs && last_o)          state_d = ST_IDLE;
                else if (hs && blk_last_o) state_d = ST_WAIT_BLK;
            end
            ST_WAIT_BLK: if (md_valid_i) state_d = ST_STREAM;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output decode from state, counters and shift register head
    always_comb begin
        in_ready_o    = (state_q != ST_STREAM);
        out_valid_o   = (state_q == ST_STREAM);
        last_o        = out_valid_o && (rem_q == LEN_W'(1));
        blk_last_o    = out_valid_o && ((idx_q == wpb_q - LEN_W'(1)) || (rem_q == LEN_W'(1)));
        squeeze_req_o = sq_q;
        done_o        = done_q;
        word          = sreg_q[0 +: OUT_W];
        // SHA3-224 at 64-bit words: the 4th word holds only 32 digest bits
        if (OUT_W == 64 && mode_q == M_SHA3_224 && idx_q == LEN_W'(3))
            word[OUT_W/2-1:0] = '0;
        dout_o        = out_valid_o ? word : '0;
    end

    // Block buffer, word/remaining counters and single-cycle status pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sreg_q <= '0;
            idx_q  <= '0;
            wpb_q  <= '0;
            rem_q  <= '0;
            mode_q <= M_SHAKE128;
            done_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            sq_q   <= 1'b0;
            if (accept) begin
                sreg_q <= din_i;
                idx_q  <= '0;
                // Mode and length are only taken with the first block of a message
                if (state_q == ST_IDLE) begin
                    mode_q <= mode_in;
                    wpb_q  <= wpb_in;
                    rem_q  <= tot_in;
                end
            end else if (hs) begin
                sreg_q <= {sreg_q[OUT_W:RATE_W-1], {OUT_W{1'b0}}};
                idx_q  <= idx_q + LEN_W'(1);
                rem_q  <= rem_q - LEN_W'(1);
                if (last_o)          done_q <= 1'b1;
                else if (blk_last_o) sq_q   <= 1'b1;
            end
        end
    end

`ifdef SHA3_SER_DROP_FLAG_EN
    // Sticky record of any block offered while the buffer was busy
    always_ff @(posedge clk) begin
        if (!reset_n) drop_o <= 1'b0;
        else if (md_valid_i && !in_ready_o) drop_o <= 1'b1;
    end
`endif

endmodule
